// File: rtl/traffic_intersection_pkg.sv
// Shared state encoding and lamp patterns for the N-approach intersection controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      PROG,
      FLASH,
      GREEN,
      YELLOW,
      ALLRED
   } state_t;

   localparam logic [2:0] LED_GREEN  = 3'b100;
   localparam logic [2:0] LED_YELLOW = 3'b010;
   localparam logic [2:0] LED_RED    = 3'b001;
   localparam logic [2:0] LED_OFF    = 3'b000;

endpackage

// File: rtl/traffic_intersection_if.sv
// Operator/control inputs and lamp/status outputs of the intersection controller.
interface traffic_intersection_if #(
   parameter int N_APPR = 4
);
   localparam int PH_W = $clog2(N_APPR);

   logic                  attention;
   logic [N_APPR-1:0]     preferential;
   logic                  preset;
   logic                  preset_add;
   logic                  force_red;
   logic [3*N_APPR-1:0]   leds;
   logic                  lgreen;
   logic [PH_W-1:0]       phase;

   modport master (
      output attention, preferential, preset, preset_add, force_red,
      input  leds, lgreen, phase
   );

   modport slave (
      input  attention, preferential, preset, preset_add, force_red,
      output leds, lgreen, phase
   );
endinterface

// File: rtl/traffic_intersection_phase_timer.sv
// Phase duration down-counter: load wins, hold freezes, otherwise counts down to zero and stops.
// Latency: done reflects the count registered on the previous edge.
// Backpressure: none; the controller reloads it on every state change.
module tl_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic             done
);
   logic [CNT_W-1:0] cnt;

   // No own reset: the controller asserts load while its reset is active.
   always_ff @(posedge clk) begin
      if (load) begin
         cnt <= load_val;
      end else if (!hold && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done = (cnt == '0);
endmodule

// File: rtl/traffic_intersection.sv
// Round-robin N-approach signal controller with preferential green, programmable extension, attention flash and force-red.
// Latency: all outputs registered; a sampled input takes effect on the lamps one cycle later.
// Backpressure: none; inputs are levels (preset_add is edge-detected) and every state is always accepted.
module traffic_intersection
   import traffic_pkg::*;
#(
   parameter int N_APPR         = 4,
   parameter int CNT_W          = 8,
   parameter int GREEN_CYC      = 60,
   parameter int PREF_GREEN_CYC = 80,
   parameter int YELLOW_CYC     = 6,
   parameter int CLR_CYC        = 4,
   parameter int FLASH_HALF     = 3,
   parameter int PRESET_STEP    = 20,
   parameter int PRESET_MAX     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   traffic_intersection_if.slave bus
);
   localparam int PH_W  = $clog2(N_APPR);
   localparam int EXT_W = $clog2(PRESET_MAX + 1);

   if (PREF_GREEN_CYC + PRESET_MAX * PRESET_STEP > 2**CNT_W - 1) begin : g_cnt_w_chk
      $error("CNT_W too narrow for the longest extended green");
   end
   if (N_APPR < 2 || N_APPR > 8) begin : g_n_appr_chk
      $error("N_APPR must be in 2..8");
   end

   state_t              state, state_nxt;
   logic [PH_W-1:0]     phase, phase_nxt;
   logic                flash_on, flash_nxt;
   logic                restart, restart_nxt;
   logic [EXT_W-1:0]    ext, ext_nxt;
   logic                add_q, add_acc;
   logic [3*N_APPR-1:0] leds, leds_nxt;
   logic                lgreen;
   logic                tmr_load, tmr_hold, tmr_done;
   logic [CNT_W-1:0]    tmr_val;
   logic [2:0]          lamp;

   function automatic logic [CNT_W-1:0] green_len(input logic pref_bit, input logic [EXT_W-1:0] e);
      logic [CNT_W-1:0] base;
      base = pref_bit ? CNT_W'(PREF_GREEN_CYC) : CNT_W'(GREEN_CYC);
      return base + CNT_W'(e) * CNT_W'(PRESET_STEP);
   endfunction

   tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .load     (tmr_load),
      .load_val (tmr_val),
      .hold     (tmr_hold),
      .done     (tmr_done)
   );

   assign add_acc  = (state == PROG) && bus.preset && bus.preset_add && !add_q
                     && (ext < EXT_W'(PRESET_MAX));
   assign tmr_hold = (state_nxt == PROG);

   // Timer is loaded with duration-1 on the edge that enters a state, so that state shows for exactly duration cycles.
   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      flash_nxt   = flash_on;
      restart_nxt = restart;
      ext_nxt     = ext;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      if (bus.preset) begin
         state_nxt = PROG;
         if (state != PROG) begin
            ext_nxt = '0;
         end else if (add_acc) begin
            ext_nxt = ext + EXT_W'(1);
         end
      end else if (state == PROG) begin
         state_nxt   = GREEN;
         phase_nxt   = '0;
         restart_nxt = 1'b0;
         tmr_load    = 1'b1;
         tmr_val     = green_len(bus.preferential[0], ext) - CNT_W'(1);
      end else if (bus.attention) begin
         state_nxt = FLASH;
         if ((state != FLASH) || tmr_done) begin
            flash_nxt = (state == FLASH) ? ~flash_on : 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = CNT_W'(FLASH_HALF - 1);
         end
      end else begin
         case (state)
            FLASH: begin
               state_nxt   = ALLRED;
               restart_nxt = 1'b1;
               tmr_load    = 1'b1;
               tmr_val     = CNT_W'(CLR_CYC - 1);
            end
            GREEN: begin
               if (bus.force_red || tmr_done) begin
                  state_nxt = YELLOW;
                  tmr_load  = 1'b1;
                  tmr_val   = CNT_W'(YELLOW_CYC - 1);
               end
            end
            YELLOW: begin
               if (tmr_done) begin
                  state_nxt = ALLRED;
                  tmr_load  = 1'b1;
                  tmr_val   = CNT_W'(CLR_CYC - 1);
               end
            end
            ALLRED: begin
               if (bus.force_red) begin
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(CLR_CYC - 1);
               end else if (tmr_done) begin
                  state_nxt   = GREEN;
                  restart_nxt = 1'b0;
                  if (restart || (phase == PH_W'(N_APPR - 1))) begin
                     phase_nxt = '0;
                  end else begin
                     phase_nxt = phase + PH_W'(1);
                  end
                  tmr_load = 1'b1;
                  tmr_val  = green_len(bus.preferential[phase_nxt], ext) - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end

      // The reset cycle itself shows dark lamps, hence the full green length here.
      if (!rst) begin
         tmr_load = 1'b1;
         tmr_val  = green_len(bus.preferential[0], '0);
      end
   end

   always_comb begin
      leds_nxt = '0;
      lamp     = LED_RED;
      for (int i = 0; i < N_APPR; i++) begin
         case (state_nxt)
            PROG:    lamp = LED_OFF;
            FLASH:   lamp = flash_nxt ? LED_YELLOW : LED_OFF;
            GREEN:   lamp = (PH_W'(i) == phase_nxt) ? LED_GREEN : LED_RED;
            YELLOW:  lamp = (PH_W'(i) == phase_nxt) ? LED_YELLOW : LED_RED;
            default: lamp = LED_RED;
         endcase
         leds_nxt[3*i +: 3] = lamp;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= GREEN;
         phase    <= '0;
         flash_on <= 1'b0;
         restart  <= 1'b0;
         ext      <= '0;
         add_q    <= 1'b0;
         leds     <= '0;
         lgreen   <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         flash_on <= flash_nxt;
         restart  <= restart_nxt;
         ext      <= ext_nxt;
         add_q    <= bus.preset_add;
         leds     <= leds_nxt;
         lgreen   <= add_acc;
      end
   end

   assign bus.leds   = leds;
   assign bus.lgreen = lgreen;
   assign bus.phase  = phase;
endmodule

// File: tb/tb_traffic_intersection.sv
// Self-checking bench for traffic_intersection with default parameters (4 approaches).
module tb_traffic_intersection;
   localparam int N    = 4;
   localparam int GRN  = 60;
   localparam int PGRN = 80;
   localparam int YEL  = 6;
   localparam int CLR  = 4;
   localparam int STEP = 20;
   localparam logic [2:0]  L_G = 3'b100;
   localparam logic [2:0]  L_Y = 3'b010;
   localparam logic [2:0]  L_R = 3'b001;
   localparam logic [11:0] ALL_RED = 12'b001_001_001_001;
   localparam logic [11:0] ALL_YEL = 12'b010_010_010_010;
   localparam int K_G = 0;
   localparam int K_Y = 1;
   localparam int K_R = 2;

   logic clk = 1'b0;
   logic rst;

   traffic_intersection_if #(.N_APPR(N)) bus ();

   traffic_intersection #(.N_APPR(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] leds;
      logic [1:0]  ph;
      int          kind;
   } exp_t;

   typedef struct {
      logic        preset;
      logic        add;
      logic [11:0] leds;
      logic        lg;
   } vec_t;

   exp_t mq[$];
   int   m_p;
   int   m_cur;
   int   m_ext;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [11:0] pat(input logic [2:0] lamp, input int a);
      logic [11:0] r;
      r = ALL_RED;
      r[3*a +: 3] = lamp;
      return r;
   endfunction

   function automatic bit any_yellow(input logic [11:0] l);
      bit r;
      r = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (l[3*i +: 3] == L_Y) r = 1'b1;
      end
      return r;
   endfunction

   function automatic vec_t mkv(input logic p, input logic a, input logic [11:0] l, input logic g);
      vec_t v;
      v.preset = p;
      v.add    = a;
      v.leds   = l;
      v.lg     = g;
      return v;
   endfunction

   // Counts how many consecutive cycles (from the current one) the lamps hold pattern p.
   task automatic run_len(input logic [11:0] p, output int n);
      n = 0;
      while (bus.leds === p && n < 2000) begin
         n++;
         tick();
      end
   endtask

   task automatic do_reset(input logic [3:0] pref);
      rst              = 1'b0;
      bus.attention    = 1'b0;
      bus.preset       = 1'b0;
      bus.preset_add   = 1'b0;
      bus.force_red    = 1'b0;
      bus.preferential = pref;
      tick();
      tick();
   endtask

   // Reference model: a queue of upcoming lamp words, refilled one whole green/yellow/clear round at a time.
   task automatic m_push(input int kind, input int n, input int a);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.kind = kind;
         e.ph   = 2'(a);
         e.leds = (kind == K_R) ? ALL_RED : pat((kind == K_G) ? L_G : L_Y, a);
         mq.push_back(e);
      end
   endtask

   task automatic model_step(input logic [3:0] pref, input logic fr, output exp_t e);
      int glen;
      if (fr && m_cur == K_G) begin
         mq.delete();
         m_push(K_Y, YEL, m_p);
         m_push(K_R, CLR, m_p);
      end else if (fr && m_cur == K_R) begin
         mq.delete();
         m_push(K_R, CLR, m_p);
      end
      if (mq.size() == 0) begin
         m_p  = (m_p + 1) % N;
         glen = (pref[m_p] ? PGRN : GRN) + m_ext * STEP;
         m_push(K_G, glen, m_p);
         m_push(K_Y, YEL, m_p);
         m_push(K_R, CLR, m_p);
      end
      e     = mq.pop_front();
      m_cur = e.kind;
   endtask

   initial begin
      vec_t vt1[$];
      vec_t vt2[$];
      exp_t e;
      int   n;
      int   hold;
      logic fr_v;

      vt1.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0));
      vt1.push_back(mkv(1'b1, 1'b1, 12'h000, 1'b1));
      vt1.push_back(mkv(1'b1, 1'b1, 12'h000, 1'b0));
      vt1.push_back(mkv(1'b1, 1'b1, 12'h000, 1'b0));
      vt1.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0));
      vt1.push_back(mkv(1'b1, 1'b1, 12'h000, 1'b1));
      vt1.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0));
      vt1.push_back(mkv(1'b0, 1'b0, pat(L_G, 0), 1'b0));
      vt2.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0));
      for (int k = 0; k < 8; k++) begin
         vt2.push_back(mkv(1'b1, 1'b1, 12'h000, 1'b1));
         vt2.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0));
      end
      vt2.push_back(mkv(1'b1, 1'b1, 12'h000, 1'b0));
      vt2.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0));

      // Reset state and plain round-robin with wrap.
      do_reset(4'b0000);
      chk("rst_leds", bus.leds, 12'h000);
      chk("rst_lgreen", bus.lgreen, 0);
      chk("rst_phase", bus.phase, 0);
      rst = 1'b1;
      tick();
      for (int a = 0; a < N; a++) begin
         chk("rr_green_on", bus.leds, pat(L_G, a));
         chk("rr_phase", bus.phase, a);
         run_len(pat(L_G, a), n);
         chk("rr_green_len", n, GRN);
         run_len(pat(L_Y, a), n);
         chk("rr_yellow_len", n, YEL);
         run_len(ALL_RED, n);
         chk("rr_clear_len", n, CLR);
      end
      chk("rr_wrap_leds", bus.leds, pat(L_G, 0));
      chk("rr_wrap_phase", bus.phase, 0);

      // Preferential approach 1, mask changed mid-green.
      do_reset(4'b0010);
      rst = 1'b1;
      tick();
      run_len(pat(L_G, 0), n);
      chk("pref_a0_len", n, GRN);
      run_len(pat(L_Y, 0), n);
      run_len(ALL_RED, n);
      n = 0;
      while (bus.leds === pat(L_G, 1) && n < 2000) begin
         n++;
         if (n == 30) bus.preferential = 4'b0000;
         tick();
      end
      chk("pref_a1_len", n, PGRN);
      bus.preferential = 4'b0010;
      run_len(pat(L_Y, 1), n);
      run_len(ALL_RED, n);
      chk("pref_a2_on", bus.leds, pat(L_G, 2));
      run_len(pat(L_G, 2), n);
      chk("pref_a2_len", n, GRN);

      // Attention during approach 1 green.
      do_reset(4'b0000);
      rst = 1'b1;
      tick();
      run_len(pat(L_G, 0), n);
      run_len(pat(L_Y, 0), n);
      run_len(ALL_RED, n);
      for (int k = 0; k < 10; k++) tick();
      bus.attention = 1'b1;
      tick();
      for (int k = 0; k < 12; k++) begin
         chk("flash_leds", bus.leds, ((k / 3) % 2 == 1) ? ALL_YEL : 12'h000);
         tick();
      end
      bus.attention = 1'b0;
      tick();
      chk("flash_exit_red", bus.leds, ALL_RED);
      run_len(ALL_RED, n);
      chk("flash_clear_len", n, CLR);
      chk("flash_exit_green", bus.leds, pat(L_G, 0));
      chk("flash_exit_phase", bus.phase, 0);

      // Force-red pulse at green cycle 10, then held 20 cycles in clearance.
      do_reset(4'b0000);
      rst = 1'b1;
      tick();
      for (int k = 0; k < 9; k++) tick();
      bus.force_red = 1'b1;
      tick();
      bus.force_red = 1'b0;
      chk("fr_yellow_on", bus.leds, pat(L_Y, 0));
      run_len(pat(L_Y, 0), n);
      chk("fr_yellow_len", n, YEL);
      chk("fr_red_on", bus.leds, ALL_RED);
      bus.force_red = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("fr_held_red", bus.leds, ALL_RED);
      end
      bus.force_red = 1'b0;
      run_len(ALL_RED, n);
      chk("fr_post_clear_len", n, CLR);
      chk("fr_next_green", bus.leds, pat(L_G, 1));
      chk("fr_next_phase", bus.phase, 1);

      // Programming: two accepted edges, held level, then extended green.
      foreach (vt1[i]) begin
         bus.preset     = vt1[i].preset;
         bus.preset_add = vt1[i].add;
         tick();
         chk($sformatf("prog1_leds[%0d]", i), bus.leds, vt1[i].leds);
         chk($sformatf("prog1_lgreen[%0d]", i), bus.lgreen, vt1[i].lg);
      end
      run_len(pat(L_G, 0), n);
      chk("ext2_green_len", n, GRN + 2 * STEP);

      // Re-entry clears ext; eight accepted edges then a saturated one.
      foreach (vt2[i]) begin
         bus.preset     = vt2[i].preset;
         bus.preset_add = vt2[i].add;
         tick();
         chk($sformatf("prog2_leds[%0d]", i), bus.leds, vt2[i].leds);
         chk($sformatf("prog2_lgreen[%0d]", i), bus.lgreen, vt2[i].lg);
      end

      // Randomized preferential masks and force-red pulses/holds against the model, ext saturated.
      mq.delete();
      m_p   = N - 1;
      m_cur = K_R;
      m_ext = 8;
      hold  = 0;
      bus.preset_add = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         bus.preset       = 1'b0;
         bus.preferential = 4'($urandom);
         if (c == 0) begin
            fr_v = 1'b0;
         end else if (hold > 0) begin
            fr_v = 1'b1;
            hold--;
         end else if ($urandom_range(0, 59) == 0) begin
            fr_v = 1'b1;
            hold = int'($urandom_range(0, 24));
         end else begin
            fr_v = 1'b0;
         end
         bus.force_red = fr_v;
         tick();
         model_step(bus.preferential, fr_v, e);
         chk("rnd_leds", bus.leds, e.leds);
         chk("rnd_phase", bus.phase, e.ph);
         chk("rnd_lgreen", bus.lgreen, 0);
      end

      // Reset arriving in yellow aborts at once and clears ext.
      bus.force_red    = 1'b0;
      bus.preferential = 4'b0000;
      n = 0;
      while (any_yellow(bus.leds) && n < 3000) begin
         tick();
         n++;
      end
      n = 0;
      while (!any_yellow(bus.leds) && n < 3000) begin
         tick();
         n++;
      end
      chk("yellow_found", any_yellow(bus.leds), 1);
      rst = 1'b0;
      tick();
      chk("midrst_leds", bus.leds, 12'h000);
      chk("midrst_phase", bus.phase, 0);
      chk("midrst_lgreen", bus.lgreen, 0);
      rst = 1'b1;
      tick();
      chk("midrst_green", bus.leds, pat(L_G, 0));
      run_len(pat(L_G, 0), n);
      chk("midrst_green_len", n, GRN);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
